// File: rtl/msg_redun_check.sv
//------------------------------------------------------------------------------
// msg_redun_check
//
// Receive stage for messages laid out as {red, src, dst, dat} (MSB..LSB).
// Each accepted message spends one cycle in a check register, where its
// redundancy field is recomputed by calc_redun and compared with the received
// one. Good messages go into a small first-word-fall-through FIFO and are
// offered downstream over valid/ready. Bad messages are dropped and counted.
//
// Optional feature macro: NS_REDUN_CHK_PASS_BAD_EN
//   When defined, bad messages are queued as well. Each FIFO entry carries a
//   sideband bit that appears on o_bad alongside o_msg. The error counter and
//   the error flag still update.
//
// Ports:
//   i_clk      clock
//   reset      synchronous reset, active-high
//   i_msg      input message {red, src, dst, dat}
//   i_vld      input message valid
//   o_rdy      input ready; a transfer happens when i_vld && o_rdy at posedge
//   o_msg      FIFO head message, passed through unchanged (red included)
//   o_vld      FIFO non-empty
//   i_rdy      downstream ready; the FIFO pops when o_vld && i_rdy
//   o_err_cnt  saturating count of bad messages
//   o_err_flag sticky flag, set by any bad message since the last clear
//   i_err_clr  clears o_err_cnt and o_err_flag
//   o_full     FIFO holds DEPTH entries
//   o_bad      (feature only) head entry failed its redundancy check
//------------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

// calc_redun: redundancy generator shared with the message source. Bit i of
// {src, dst, dat} is folded by XOR into redundancy bit (i mod RSZ).
module calc_redun #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] i_src,
  input  logic [ASZ-1:0] i_dst,
  input  logic [DSZ-1:0] i_dat,
  output logic [RSZ-1:0] o_red
);
  localparam int WSZ = 2*ASZ + DSZ;

  logic [WSZ-1:0] w_all;

  assign w_all = {i_src, i_dst, i_dat};

  // XOR-fold the payload down to RSZ bits
  always_comb begin
    o_red = '0;
    for (int r = 0; r < RSZ; r++) begin
      for (int j = r; j < WSZ; j += RSZ) begin
        o_red[r] = o_red[r] ^ w_all[j];
      end
    end
  end
endmodule

module msg_redun_check #(
  parameter  int ASZ = `NS_ADDRESS_SIZE,
  parameter  int DSZ = `NS_DATA_SIZE,
  parameter  int RSZ = `NS_REDUN_SIZE,
  parameter  int FSZ = 2,
  parameter  int ESZ = 8,
  localparam int MSZ = RSZ + 2*ASZ + DSZ
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [MSZ-1:0] i_msg,
  input  logic           i_vld,
  output logic           o_rdy,
  output logic [MSZ-1:0] o_msg,
  output logic           o_vld,
  input  logic           i_rdy,
  output logic [ESZ-1:0] o_err_cnt,
  output logic           o_err_flag,
  input  logic           i_err_clr,
  output logic           o_full
`ifdef NS_REDUN_CHK_PASS_BAD_EN
  ,
  output logic           o_bad
`endif
);
  localparam int             DEPTH     = 1 << FSZ;
  localparam logic [FSZ+1:0] DEPTH_OCC = (FSZ+2)'(DEPTH);
  localparam logic [FSZ:0]   DEPTH_CNT = (FSZ+1)'(DEPTH);

  logic [MSZ-1:0] r_s1_msg;
  logic           r_s1_vld;
  logic [MSZ-1:0] r_mem [DEPTH];
  logic [FSZ-1:0] r_wr_ptr;
  logic [FSZ-1:0] r_rd_ptr;
  logic [FSZ:0]   r_count;
  logic [ESZ-1:0] r_err_cnt;
  logic           r_err_flag;

  logic [RSZ-1:0] w_s1_red;
  logic [ASZ-1:0] w_s1_src;
  logic [ASZ-1:0] w_s1_dst;
  logic [DSZ-1:0] w_s1_dat;
  logic [RSZ-1:0] w_calc_red;
  logic           w_mismatch;
  logic           w_bad;
  logic           w_push;
  logic           w_pop;
  logic           w_xfer;
  logic [FSZ+1:0] w_occ;

  assign w_s1_red = r_s1_msg[MSZ-1 -: RSZ];
  assign w_s1_src = r_s1_msg[2*ASZ+DSZ-1 -: ASZ];
  assign w_s1_dst = r_s1_msg[ASZ+DSZ-1 -: ASZ];
  assign w_s1_dat = r_s1_msg[DSZ-1:0];

  calc_redun #(
    .ASZ (ASZ),
    .DSZ (DSZ),
    .RSZ (RSZ)
  ) u_calc_redun (
    .i_src (w_s1_src),
    .i_dst (w_s1_dst),
    .i_dat (w_s1_dat),
    .o_red (w_calc_red)
  );

  assign w_mismatch = (w_calc_red != w_s1_red);
  assign w_bad      = r_s1_vld & w_mismatch;
`ifdef NS_REDUN_CHK_PASS_BAD_EN
  assign w_push     = r_s1_vld;
`else
  assign w_push     = r_s1_vld & ~w_mismatch;
`endif
  assign w_pop      = (r_count != '0) & i_rdy;

  // Counting the message already in the check stage reserves a FIFO slot for
  // it, so a push never meets a full FIFO and no stall path is needed.
  assign w_occ  = {1'b0, r_count} + {{(FSZ+1){1'b0}}, r_s1_vld};
  assign o_rdy  = (w_occ < DEPTH_OCC);
  assign w_xfer = i_vld & o_rdy;

  // The check stage holds a message for exactly one cycle
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_xfer;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      r_s1_msg <= i_msg;
    end
  end

  // FIFO storage carries no reset; the pointers and count define validity
  always_ff @(posedge i_clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= r_s1_msg;
    end
  end

  // Pointers wrap naturally; a separate count distinguishes full from empty
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A bad message checked on the same edge as a clear still counts, so the
  // counter restarts at 1 and the flag stays set
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (w_bad) begin
      r_err_flag <= 1'b1;
      if (i_err_clr) begin
        r_err_cnt <= ESZ'(1);
      end else if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end else if (i_err_clr) begin
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end
  end

`ifdef NS_REDUN_CHK_PASS_BAD_EN
  logic r_bad_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!reset && w_push) begin
      r_bad_mem[r_wr_ptr] <= w_mismatch;
    end
  end

  assign o_bad = r_bad_mem[r_rd_ptr];
`endif

  assign o_msg      = r_mem[r_rd_ptr];
  assign o_vld      = (r_count != '0);
  assign o_full     = (r_count == DEPTH_CNT);
  assign o_err_cnt  = r_err_cnt;
  assign o_err_flag = r_err_flag;
endmodule

// File: tb/tb_msg_redun_check.sv
//------------------------------------------------------------------------------
// tb_msg_redun_check
//
// Scoreboard bench for msg_redun_check. The driver predicts which messages
// must come out (good ones, in order) and pushes them into a queue; a monitor
// compares every downstream handshake against the head of that queue. The
// reference redundancy is computed by chunk-wise XOR of the payload.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module tb_msg_redun_check;
  localparam int ASZ   = `NS_ADDRESS_SIZE;
  localparam int DSZ   = `NS_DATA_SIZE;
  localparam int RSZ   = `NS_REDUN_SIZE;
  localparam int FSZ   = 2;
  localparam int ESZ   = 8;
  localparam int DEPTH = 1 << FSZ;
  localparam int MSZ   = RSZ + 2*ASZ + DSZ;
  localparam int ERR_MAX = (1 << ESZ) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [MSZ-1:0] i_msg = '0;
  logic           i_vld = 1'b0;
  logic           o_rdy;
  logic [MSZ-1:0] o_msg;
  logic           o_vld;
  logic           i_rdy = 1'b0;
  logic [ESZ-1:0] o_err_cnt;
  logic           o_err_flag;
  logic           i_err_clr = 1'b0;
  logic           o_full;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [MSZ-1:0] expQ [$];
  int expErr  = 0;
  bit expFlag = 1'b0;

  msg_redun_check #(
    .ASZ (ASZ),
    .DSZ (DSZ),
    .RSZ (RSZ),
    .FSZ (FSZ),
    .ESZ (ESZ)
  ) dut (
    .i_clk      (clk),
    .reset      (reset),
    .i_msg      (i_msg),
    .i_vld      (i_vld),
    .o_rdy      (o_rdy),
    .o_msg      (o_msg),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy),
    .o_err_cnt  (o_err_cnt),
    .o_err_flag (o_err_flag),
    .i_err_clr  (i_err_clr),
    .o_full     (o_full)
  );

  always #5 clk = ~clk;

  // Reference redundancy: XOR together successive RSZ-bit chunks of the payload
  function automatic logic [RSZ-1:0] refRed(input logic [ASZ-1:0] src,
                                            input logic [ASZ-1:0] dst,
                                            input logic [DSZ-1:0] dat);
    longint unsigned rest;
    longint unsigned acc;
    longint unsigned mask;
    rest = longint'({src, dst, dat});
    mask = (64'd1 << RSZ) - 64'd1;
    acc  = 0;
    while (rest != 0) begin
      acc  = acc ^ (rest & mask);
      rest = rest >> RSZ;
    end
    return RSZ'(acc);
  endfunction

  function automatic logic [MSZ-1:0] makeMsg(input int src, input int dst,
                                             input int dat, input int corrupt);
    logic [ASZ-1:0] s;
    logic [ASZ-1:0] d;
    logic [DSZ-1:0] t;
    s = ASZ'(src);
    d = ASZ'(dst);
    t = DSZ'(dat);
    return {refRed(s, d, t) ^ RSZ'(corrupt), s, d, t};
  endfunction

  function automatic bit msgIsGood(input logic [MSZ-1:0] m);
    logic [RSZ-1:0] red;
    logic [ASZ-1:0] s;
    logic [ASZ-1:0] d;
    logic [DSZ-1:0] t;
    {red, s, d, t} = m;
    return red == refRed(s, d, t);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge; if the DUT will take
  // the message on the next edge, the model decides its fate right away
  task automatic applyStimulus(input logic vld, input logic [MSZ-1:0] msg,
                               input logic rdy, output bit accepted);
    @(posedge clk);
    #1;
    i_vld = vld;
    i_msg = msg;
    i_rdy = rdy;
    accepted = vld && o_rdy && !reset;
    if (accepted) begin
      if (msgIsGood(msg)) begin
        expQ.push_back(msg);
      end else begin
        if (expErr < ERR_MAX) expErr++;
        expFlag = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, acc);
  endtask

  task automatic waitDrain(input string name);
    bit acc;
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      applyStimulus(1'b0, '0, 1'b1, acc);
      n++;
    end
    idle(2, 1'b1);
    checkOutput({name, "_drained"}, 64'(expQ.size()), 64'd0);
    checkOutput({name, "_vld_low"}, 64'(o_vld), 64'd0);
  endtask

  // Monitor: every handshake must present the oldest outstanding good message
  always @(negedge clk) begin
    if (reset === 1'b0 && o_vld === 1'b1 && i_rdy === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL out_unexpected: got 0x%0h, expected no output", o_msg);
      end else begin
        checkOutput("out_msg", 64'(o_msg), 64'(expQ.pop_front()));
      end
    end
  end

  initial begin
    bit acc;
    int k;
    logic [MSZ-1:0] m;
    logic [MSZ-1:0] fillMsg [DEPTH+2];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_vld",  64'(o_vld),      64'd0);
    checkOutput("rst_full", 64'(o_full),     64'd0);
    checkOutput("rst_cnt",  64'(o_err_cnt),  64'd0);
    checkOutput("rst_flag", 64'(o_err_flag), 64'd0);
    checkOutput("rst_rdy",  64'(o_rdy),      64'd1);

    // Single good message: visible after the second edge following acceptance
    m = makeMsg(1, 2, 3, 0);
    applyStimulus(1'b1, m, 1'b1, acc);
    checkOutput("good_acc", 64'(acc), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("good_vld_early", 64'(o_vld), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("good_vld",  64'(o_vld),     64'd1);
    checkOutput("good_msg",  64'(o_msg),     64'(m));
    checkOutput("good_cnt",  64'(o_err_cnt), 64'd0);
    waitDrain("good");

    // Same message with red bit 0 inverted: dropped and counted
    m = makeMsg(1, 2, 3, 1);
    applyStimulus(1'b1, m, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("bad_cnt_early", 64'(o_err_cnt), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, acc);
    checkOutput("bad_cnt",  64'(o_err_cnt),  64'd1);
    checkOutput("bad_flag", 64'(o_err_flag), 64'd1);
    checkOutput("bad_vld",  64'(o_vld),      64'd0);
    waitDrain("bad");

    // Backpressure: with the consumer stalled only DEPTH messages get in
    for (int i = 0; i < DEPTH + 2; i++) fillMsg[i] = makeMsg(i, i + 1, 17 * i + 5, 0);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(k < DEPTH + 2, (k < DEPTH + 2) ? fillMsg[k] : '0, 1'b0, acc);
      if (acc) k++;
    end
    checkOutput("fill_transfers", 64'(k), 64'(DEPTH));
    idle(2, 1'b0);
    checkOutput("fill_full", 64'(o_full), 64'd1);
    checkOutput("fill_rdy",  64'(o_rdy),  64'd0);
    waitDrain("fill");
    checkOutput("fill_not_full", 64'(o_full), 64'd0);

    // Random stream, random downstream ready, about a quarter corrupted
    for (int c = 0; c < 400; c++) begin
      int corrupt;
      corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (1 << RSZ) - 1)) : 0;
      m = makeMsg(int'($urandom), int'($urandom), int'($urandom), corrupt);
      applyStimulus($urandom_range(0, 9) < 8, m, 1'($urandom_range(0, 1)), acc);
    end
    waitDrain("rand");
    checkOutput("rand_cnt",  64'(o_err_cnt),  64'(expErr));
    checkOutput("rand_flag", 64'(o_err_flag), 64'(expFlag));

    // Saturation of the error counter
    for (int c = 0; c < 300; c++) begin
      m = makeMsg(c, c + 3, c * 7, 4);
      applyStimulus(1'b1, m, 1'b1, acc);
    end
    idle(3, 1'b1);
    checkOutput("sat_cnt",  64'(o_err_cnt),  64'(ERR_MAX));
    checkOutput("sat_flag", 64'(o_err_flag), 64'd1);
    checkOutput("sat_vld",  64'(o_vld),      64'd0);

    // Clear on the same edge a bad message is checked: the error wins
    applyStimulus(1'b1, makeMsg(5, 6, 7, 2), 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, acc);
    i_err_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, acc);
    i_err_clr = 1'b0;
    expErr = 1;
    checkOutput("clr_bad_cnt",  64'(o_err_cnt),  64'(expErr));
    checkOutput("clr_bad_flag", 64'(o_err_flag), 64'd1);
    i_err_clr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, acc);
    i_err_clr = 1'b0;
    expErr  = 0;
    expFlag = 1'b0;
    checkOutput("clr_cnt",  64'(o_err_cnt),  64'd0);
    checkOutput("clr_flag", 64'(o_err_flag), 64'd0);

    // Reset with three good messages queued and a bad one in the check stage
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, makeMsg(i + 8, i, i + 40, 0), 1'b0, acc);
    applyStimulus(1'b1, makeMsg(9, 9, 9, 8), 1'b0, acc);
    checkOutput("pre_rst_acc", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    reset = 1'b1;
    checkOutput("pre_rst_vld", 64'(o_vld), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    expErr  = 0;
    expFlag = 1'b0;
    checkOutput("post_rst_vld",  64'(o_vld),      64'd0);
    checkOutput("post_rst_full", 64'(o_full),     64'd0);
    checkOutput("post_rst_cnt",  64'(o_err_cnt),  64'd0);
    checkOutput("post_rst_flag", 64'(o_err_flag), 64'd0);
    idle(2, 1'b1);
    checkOutput("post_rst_cnt2", 64'(o_err_cnt), 64'd0);
    checkOutput("post_rst_vld2", 64'(o_vld),     64'd0);
    m = makeMsg(3, 12, 200, 0);
    applyStimulus(1'b1, m, 1'b1, acc);
    checkOutput("post_rst_acc", 64'(acc), 64'd1);
    waitDrain("post_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
